ram_read_scanner: RTL and testbench



---
 rtl/ram_read_scanner.sv | 103 ++++++++++
 tb/tb_ram_read_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_scanner.sv
// Slow scanner over a synchronous RAM: reads one word, shows it, waits a tick period, then moves on.
// Writes that hit the shown or in-flight address force a re-read so the display never goes stale.
module ram_read_scanner #(
  parameter int unsigned TICK_COUNT = 52428800,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              step,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam int unsigned CNT_W = $clog2(TICK_COUNT) + 1;
  localparam int unsigned LAT_W = $clog2(RD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_COUNT - 1);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LATENCY - 1);

  typedef enum logic {
    ST_READ = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tick_cnt, tick_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt, disp_addr_nxt;
  logic [DATA_W-1:0] disp_data_nxt;
  logic              disp_valid_nxt;

  // Next-state and datapath decisions; refresh on a coherent write outranks tick and step.
  always_comb begin
    state_nxt      = state;
    tick_nxt       = tick_cnt;
    lat_nxt        = lat_cnt;
    rd_addr_nxt    = rd_addr;
    disp_addr_nxt  = disp_addr;
    disp_data_nxt  = disp_data;
    disp_valid_nxt = 1'b0;
    case (state)
      ST_READ: begin
        if (wr_en && (wr_addr == rd_addr)) begin
          lat_nxt = '0;
        end else if (lat_cnt == LAT_LAST) begin
          disp_data_nxt  = rd_data;
          disp_addr_nxt  = rd_addr;
          disp_valid_nxt = 1'b1;
          lat_nxt        = '0;
          state_nxt      = ST_WAIT;
        end else begin
          lat_nxt = lat_cnt + LAT_W'(1);
        end
      end
      ST_WAIT: begin
        if (wr_en && (wr_addr == disp_addr)) begin
          state_nxt = ST_READ;
        end else if (enable) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt    = '0;
            rd_addr_nxt = rd_addr + ADDR_W'(1);
            state_nxt   = ST_READ;
          end else begin
            tick_nxt = tick_cnt + CNT_W'(1);
          end
        end else if (step) begin
          tick_nxt    = '0;
          rd_addr_nxt = rd_addr + ADDR_W'(1);
          state_nxt   = ST_READ;
        end
      end
      default: state_nxt = ST_READ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_READ;
      tick_cnt   <= '0;
      lat_cnt    <= '0;
      rd_addr    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      lat_cnt    <= lat_nxt;
      rd_addr    <= rd_addr_nxt;
      disp_addr  <= disp_addr_nxt;
      disp_data  <= disp_data_nxt;
      disp_valid <= disp_valid_nxt;
    end
  end

endmodule

// File: tb/tb_ram_read_scanner.sv
// Bench for ram_read_scanner: directed scenarios with literal expectations, then random traffic
// against a deadline-based reference model and a one-cycle registered-read RAM.
module tb_ram_read_scanner;

  localparam int unsigned TICK = 3;
  localparam int unsigned LAT  = 2;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable, step, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr, disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;

  int tests = 0;
  int fails = 0;

  ram_read_scanner #(
    .TICK_COUNT(TICK), .RD_LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_data(rd_data),
    .rd_addr(rd_addr), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid)
  );

  always #5 clk = ~clk;

  // RAM: address comes from the scanner's register, q is registered here -> two clocks total.
  logic [DW-1:0] mem [0:31];
  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Reference model: a READ is a deadline (cycle number of the capture edge); WAIT counts ticks.
  int            cyc = 0;
  int            m_cap_at = LAT;
  int            m_ticks = 0;
  logic [AW-1:0] m_rd = '0;
  logic [AW-1:0] m_daddr = '0;
  logic [DW-1:0] m_ddata = '0;
  logic          m_valid = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; m_cap_at = LAT; m_ticks = 0;
      m_rd = '0; m_daddr = '0; m_ddata = '0; m_valid = 1'b0;
    end else begin
      cyc = cyc + 1;
      m_valid = 1'b0;
      if (m_cap_at >= 0) begin
        if (wr_en && wr_addr == m_rd) m_cap_at = cyc + LAT;
        else if (cyc == m_cap_at) begin
          m_daddr = m_rd; m_ddata = mem[m_rd]; m_valid = 1'b1; m_cap_at = -1;
        end
      end else if (wr_en && wr_addr == m_daddr) begin
        m_cap_at = cyc + LAT;
      end else if (enable) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == TICK) begin
          m_ticks = 0; m_rd = AW'(m_rd + 1); m_cap_at = cyc + LAT;
        end
      end else if (step) begin
        m_ticks = 0; m_rd = AW'(m_rd + 1); m_cap_at = cyc + LAT;
      end
    end
  end

  // Every-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    logic [AW-1:0] e_rd, e_da;
    logic [DW-1:0] e_dd;
    logic          e_v;
    if (reset) begin e_rd = '0; e_da = '0; e_dd = '0; e_v = 1'b0; end
    else begin e_rd = m_rd; e_da = m_daddr; e_dd = m_ddata; e_v = m_valid; end
    tests = tests + 1;
    if (rd_addr !== e_rd || disp_addr !== e_da || disp_data !== e_dd || disp_valid !== e_v) begin
      fails = fails + 1;
      $display("FAIL model_cmp t=%0t got rd_addr=%0d disp_addr=%0d disp_data=%0h disp_valid=%0b expected %0d %0d %0h %0b",
               $time, rd_addr, disp_addr, disp_data, disp_valid, e_rd, e_da, e_dd, e_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin cyc_n(1); if (disp_valid) pulses = pulses + 1; end
  endtask

  initial begin
    int p;
    enable = 1'b1; step = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < 32; i++) mem[i] <= DW'(i);
    #1 reset = 1'b1;
    cyc_n(3);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_disp_addr", int'(disp_addr), 0);
    chk("reset_disp_data", int'(disp_data), 0);
    chk("reset_disp_valid", int'(disp_valid), 0);
    reset = 1'b0;

    // Pulses in cycles 3, 8, 13 after release carry addresses 0, 1, 2.
    for (int k = 1; k <= 13; k++) begin
      cyc_n(1);
      if (k == 2 || k == 7 || k == 12) begin
        chk($sformatf("first_valid_k%0d", k), int'(disp_valid), 1);
        chk($sformatf("first_addr_k%0d", k), int'(disp_addr), (k - 2) / 5);
        chk($sformatf("first_data_k%0d", k), int'(disp_data), (k - 2) / 5);
      end else begin
        chk($sformatf("first_idle_k%0d", k), int'(disp_valid), 0);
      end
    end

    // Wrap: address 31 shows after edge 157, address 0 again after edge 162.
    cyc_n(144);
    chk("wrap31_valid", int'(disp_valid), 1);
    chk("wrap31_addr", int'(disp_addr), 31);
    chk("wrap31_data", int'(disp_data), 15);
    chk("wrap31_rd_addr", int'(rd_addr), 31);
    cyc_n(5);
    chk("wrap0_valid", int'(disp_valid), 1);
    chk("wrap0_addr", int'(disp_addr), 0);
    chk("wrap0_data", int'(disp_data), 0);
    chk("wrap0_rd_addr", int'(rd_addr), 0);

    // Pause at address 4, then single-step; a step during READ is ignored.
    cyc_n(20);
    chk("pause_at4_addr", int'(disp_addr), 4);
    enable = 1'b0;
    count_pulses(20, p);
    chk("pause_no_pulse", p, 0);
    step = 1'b1; cyc_n(1); step = 1'b0;
    chk("step_read1_idle", int'(disp_valid), 0);
    cyc_n(1); step = 1'b1;
    chk("step_read2_idle", int'(disp_valid), 0);
    cyc_n(1); step = 1'b0;
    chk("step_valid", int'(disp_valid), 1);
    chk("step_addr", int'(disp_addr), 5);
    chk("step_data", int'(disp_data), 5);
    count_pulses(10, p);
    chk("step_in_read_ignored_pulses", p, 0);
    chk("step_in_read_ignored_addr", int'(rd_addr), 5);

    // Refresh on write to the displayed address; a write elsewhere changes nothing.
    step = 1'b1; cyc_n(1); step = 1'b0; cyc_n(2);
    chk("at6_addr", int'(disp_addr), 6);
    wr_en = 1'b1; wr_addr = AW'(6); wr_data = DW'(4'hA);
    cyc_n(1); wr_en = 1'b0; cyc_n(2);
    chk("refresh_valid", int'(disp_valid), 1);
    chk("refresh_addr", int'(disp_addr), 6);
    chk("refresh_data", int'(disp_data), 10);
    chk("refresh_rd_addr", int'(rd_addr), 6);
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = DW'(4'h3);
    cyc_n(1); wr_en = 1'b0;
    count_pulses(10, p);
    chk("other_write_no_refresh", p, 0);

    // Write to the in-flight address restarts the latency and the new word is shown.
    step = 1'b1; cyc_n(1); step = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = DW'(4'hC);
    cyc_n(1); wr_en = 1'b0;
    chk("restart_idle1", int'(disp_valid), 0);
    cyc_n(1);
    chk("restart_idle2", int'(disp_valid), 0);
    cyc_n(1);
    chk("restart_valid", int'(disp_valid), 1);
    chk("restart_addr", int'(disp_addr), 7);
    chk("restart_data", int'(disp_data), 12);

    // Asynchronous reset in the middle of a READ.
    step = 1'b1; cyc_n(1); step = 1'b0;
    reset = 1'b1; #1;
    chk("midread_rst_rd_addr", int'(rd_addr), 0);
    chk("midread_rst_disp_addr", int'(disp_addr), 0);
    chk("midread_rst_disp_data", int'(disp_data), 0);
    chk("midread_rst_valid", int'(disp_valid), 0);
    cyc_n(2);
    reset = 1'b0;
    enable = 1'b1;

    // Random traffic, checked every cycle by the model comparison.
    for (int i = 0; i < 3000; i++) begin
      cyc_n(1);
      enable  = ($urandom_range(0, 9) < 6);
      step    = ($urandom_range(0, 7) == 0);
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_addr = ($urandom_range(0, 2) == 0) ? m_rd : AW'($urandom_range(0, 31));
      wr_data = DW'($urandom_range(0, 15));
      reset   = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0; wr_en = 1'b0; step = 1'b0;
    cyc_n(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
